time_date_tracker: RTL
======================

# time_date_tracker

Successor to the MSF time/date decoder. It decodes each received MSF minute frame, requires a configurable number of consecutive self-consistent frames before declaring lock, and then keeps a local BCD calendar/clock. During holdover, that clock free-runs on minute boundaries when frames are corrupt. It sits between the bit slicer (which drives `bits_*`) and the display/format logic.

## Interface
- `CONFIRM_FRAMES`, default 2: consecutive consistent good frames needed to lock; legal range 1..15.
- `HOLDOVER_MINUTES`, default 30: bad minutes tolerated in holdover before lock is dropped; legal range 1..255.

- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `bits_valid_i` in 1: one-cycle strobe; one decoded second is present on `bits_data_i`.
- `bits_is_second_00_i` in 1: high while the current second is second 00; may stay high for several cycles.
- `bits_data_i` in 2: { B, A } bits for this second.
- `year_h_o`, `year_l_o` out 4,4: held BCD year.
- `month_h_o`, `month_l_o` out 1,4: held BCD month.
- `day_h_o`, `day_l_o` out 2,4: held BCD day.
- `dow_o` out 3: held day of week, 0..6.
- `hour_h_o`, `hour_l_o` out 2,4: held BCD hour.
- `minute_h_o`, `minute_l_o` out 3,4: held BCD minute.
- `valid_o` out 1: held time is trustworthy; high in LOCKED or HOLDOVER.
- `holdover_o` out 1: high in HOLDOVER.
- `update_o` out 1: one-cycle pulse when the held time changes while `valid_o` is high.
- `frame_error_o` out 1: one-cycle pulse at a boundary where the frame was bad, or was good but inconsistent.

## Operation
- **Shift registers**
  - A bits 17..59 and B bits 54..57 shift in on `bits_valid_i`, LSB-first toward second 17.
  - Field bit order is MSB at the lowest second number; the shifter swaps bits into BCD.
- **Boundary detection**
  - Boundary = rising edge of `bits_is_second_00_i`, detected with a registered previous value.
  - The frame is evaluated from the pre-shift register contents on that cycle.
- **Good frame** requires all of the following:
  - A[52..59] = 01111110.
  - B54..B57 odd parity over A17–24, A25–35, A36–38 and A39–51 respectively.
  - Range checks:
    - year digits ≤ 9;
    - month 01..12;
    - day 01..days_in_month;
    - dow ≤ 6;
    - hour 00..23;
    - minute 00..59.
- **days_in_month**
  - 31 or 30 per month.
  - February is 29 in a leap year, else 28.
  - Leap year (2000–2099): tens even with units in {0,4,8}, or tens odd with units in {2,6}.
- **Increment (held + 1 minute)**
  - Minute 59→00 carries to hour; hour 23→00 carries to day and dow.
  - dow 6→0.
  - Day rolls past days_in_month to 01 and carries to month.
  - Month 12→01 carries to year; year 99→00.
- **Consistent** = the decoded frame equals held + 1 minute over all fields.
- **State machine**, evaluated only at a boundary (state and counters hold otherwise):
  - **UNLOCKED**
    - Good frame: load; cnt=1; go to LOCKED if CONFIRM_FRAMES==1, else CONFIRMING.
    - Bad frame: no change.
  - **CONFIRMING**
    - Good and consistent: load; cnt++; go to LOCKED when cnt reaches CONFIRM_FRAMES.
    - Good but inconsistent: load; cnt=1; pulse `frame_error_o`.
    - Bad: go to UNLOCKED; cnt=0; pulse `frame_error_o`.
  - **LOCKED**
    - Good and consistent: load.
    - Good but inconsistent: load; go to CONFIRMING; cnt=1; pulse `frame_error_o`.
    - Bad: held = held+1; miss=1; go to HOLDOVER (or UNLOCKED if HOLDOVER_MINUTES==1); pulse `frame_error_o`.
  - **HOLDOVER**
    - Good and consistent: load; miss=0; go to LOCKED.
    - Good but inconsistent: load; go to CONFIRMING; cnt=1; miss=0; pulse error.
    - Bad: held = held+1; miss++; go to UNLOCKED when miss reaches HOLDOVER_MINUTES; pulse error.
- **Held registers** change only via load or increment.
  - In UNLOCKED they keep their last value, but `valid_o`=0.
- **Counter widths:** cnt is 4 bits and miss is 8 bits; both saturate and never wrap.

## Timing
- **Latency:** the boundary is sampled at edge N.
  - Held fields, state, `valid_o` and `holdover_o` take their new values after edge N.
  - `update_o` and `frame_error_o` are high for exactly the cycle after edge N.
- **`update_o`** pulses when the post-boundary state is LOCKED or HOLDOVER and held was loaded or incremented.
  - It also pulses on the transition into LOCKED.
- **Simultaneous `bits_valid_i` and boundary:** the frame is evaluated first, then the shift applies.
- **Stuck-high `bits_is_second_00_i`:** it yields only one evaluation.
- **Reset:** wins over every other input on the same edge, including mid-confirmation or mid-holdover.
  - Clears the shift registers, held fields (all 0), cnt, miss and the edge register.
  - State = UNLOCKED.
  - All outputs are 0 on the first cycle after reset.

## Test plan
- **Lock:** send two good consistent frames, 2024-02-28 Wed 23:58 then 23:59 → after the 2nd boundary, `valid_o`=1, `update_o` pulses once, and the held time is 23:59.
- **Leap-year holdover:** from the locked state above, send two bad frames (B57 flipped) → held 2024-02-29 00:00 then 00:01, `holdover_o`=1, and `frame_error_o` pulses twice.
- **Year and month wrap:** holdover from 2099-12-31 23:59 dow 6 → 2000-01-01 00:00 dow 0; separately, 2023-02-28 23:59 → 03-01.
- **Holdover expiry:** with HOLDOVER_MINUTES=3, send three bad frames → `valid_o` drops after the 3rd boundary, held stays at +3 min, state UNLOCKED.
- **Mismatch:** while LOCKED, send a good frame +5 min → loaded, `valid_o`=0 (CONFIRMING), `frame_error_o` pulses; one following consistent frame → LOCKED again.
- **Reset and boundary hold:** assert `rst_i` during HOLDOVER together with a boundary → all outputs 0, no pulse; hold `bits_is_second_00_i` high for 5 cycles → only one evaluation.

Source files
------------

// File: rtl/time_date_tracker.sv
// MSF time/date tracker: decodes minute frames, confirms lock over several
// consecutive consistent frames and keeps a BCD clock through holdover.
module time_date_tracker #(
    parameter int CONFIRM_FRAMES   = 2,
    parameter int HOLDOVER_MINUTES = 30
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bits_valid_i,
    input  logic       bits_is_second_00_i,
    input  logic [1:0] bits_data_i,
    output logic [3:0] year_h_o,
    output logic [3:0] year_l_o,
    output logic       month_h_o,
    output logic [3:0] month_l_o,
    output logic [1:0] day_h_o,
    output logic [3:0] day_l_o,
    output logic [2:0] dow_o,
    output logic [1:0] hour_h_o,
    output logic [3:0] hour_l_o,
    output logic [2:0] minute_h_o,
    output logic [3:0] minute_l_o,
    output logic       valid_o,
    output logic       holdover_o,
    output logic       update_o,
    output logic       frame_error_o
);

    // Field order matches the on-air order, so the packed value is the
    // frame's seconds 17..51 read MSB first.
    typedef struct packed {
        logic [3:0] year_h;
        logic [3:0] year_l;
        logic       month_h;
        logic [3:0] month_l;
        logic [1:0] day_h;
        logic [3:0] day_l;
        logic [2:0] dow;
        logic [1:0] hour_h;
        logic [3:0] hour_l;
        logic [2:0] minute_h;
        logic [3:0] minute_l;
    } cal_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_CONFIRMING,
        ST_LOCKED,
        ST_HOLDOVER
    } state_t;

    localparam logic [3:0] CONFIRM_N  = 4'(CONFIRM_FRAMES);
    localparam logic [7:0] HOLDOVER_N = 8'(HOLDOVER_MINUTES);

    function automatic logic is_leap(input logic [3:0] yh, input logic [3:0] yl);
        if (yh[0] == 1'b0) return (yl == 4'd0) || (yl == 4'd4) || (yl == 4'd8);
        else               return (yl == 4'd2) || (yl == 4'd6);
    endfunction

    function automatic logic [4:0] month_bin(input cal_t t);
        return 5'(t.month_h) * 5'd10 + 5'(t.month_l);
    endfunction

    function automatic logic [5:0] day_bin(input cal_t t);
        return 6'(t.day_h) * 6'd10 + 6'(t.day_l);
    endfunction

    function automatic logic [4:0] days_in_month(input cal_t t);
        case (month_bin(t))
            5'd2:                      return is_leap(t.year_h, t.year_l) ? 5'd29 : 5'd28;
            5'd4, 5'd6, 5'd9, 5'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    // a[i] holds A(17+i); each field arrives MSB first, so bits are swapped here.
    function automatic cal_t decode(input logic [42:0] a);
        cal_t d;
        d.year_h   = {a[0], a[1], a[2], a[3]};
        d.year_l   = {a[4], a[5], a[6], a[7]};
        d.month_h  = a[8];
        d.month_l  = {a[9], a[10], a[11], a[12]};
        d.day_h    = {a[13], a[14]};
        d.day_l    = {a[15], a[16], a[17], a[18]};
        d.dow      = {a[19], a[20], a[21]};
        d.hour_h   = {a[22], a[23]};
        d.hour_l   = {a[24], a[25], a[26], a[27]};
        d.minute_h = {a[28], a[29], a[30]};
        d.minute_l = {a[31], a[32], a[33], a[34]};
        return d;
    endfunction

    // b[j] holds B(54+j); parity bits make each protected group odd.
    function automatic logic frame_ok(input logic [42:0] a, input logic [5:0] b, input cal_t d);
        logic marker_ok, parity_ok, range_ok;
        marker_ok = (a[42:35] == 8'b0111_1110);
        parity_ok = (^{b[0], a[7:0]})   && (^{b[1], a[18:8]}) &&
                    (^{b[2], a[21:19]}) && (^{b[3], a[34:22]});
        range_ok  = (d.year_h <= 4'd9) && (d.year_l <= 4'd9) &&
                    (d.month_l <= 4'd9) && (month_bin(d) >= 5'd1) && (month_bin(d) <= 5'd12) &&
                    (d.day_l <= 4'd9) && (day_bin(d) >= 6'd1) &&
                    (day_bin(d) <= 6'(days_in_month(d))) &&
                    (d.dow <= 3'd6) &&
                    (d.hour_l <= 4'd9) && ((d.hour_h < 2'd2) || (d.hour_l <= 4'd3)) &&
                    (d.hour_h <= 2'd2) &&
                    (d.minute_h <= 3'd5) && (d.minute_l <= 4'd9);
        return marker_ok && parity_ok && range_ok;
    endfunction

    // One-minute BCD increment with calendar carries.
    function automatic cal_t increment(input cal_t t);
        cal_t n;
        logic c_hour, c_day, c_month, c_year;
        n       = t;
        c_hour  = (t.minute_h == 3'd5) && (t.minute_l == 4'd9);
        c_day   = c_hour && (t.hour_h == 2'd2) && (t.hour_l == 4'd3);
        c_month = c_day && (day_bin(t) >= 6'(days_in_month(t)));
        c_year  = c_month && t.month_h && (t.month_l == 4'd2);
        if (t.minute_l == 4'd9) begin
            n.minute_l = 4'd0;
            n.minute_h = c_hour ? 3'd0 : t.minute_h + 3'd1;
        end else begin
            n.minute_l = t.minute_l + 4'd1;
        end
        if (c_day) begin
            n.hour_h = 2'd0;
            n.hour_l = 4'd0;
            n.dow    = (t.dow >= 3'd6) ? 3'd0 : t.dow + 3'd1;
        end else if (c_hour) begin
            if (t.hour_l == 4'd9) begin
                n.hour_l = 4'd0;
                n.hour_h = t.hour_h + 2'd1;
            end else begin
                n.hour_l = t.hour_l + 4'd1;
            end
        end
        if (c_month) begin
            n.day_h = 2'd0;
            n.day_l = 4'd1;
        end else if (c_day) begin
            if (t.day_l == 4'd9) begin
                n.day_l = 4'd0;
                n.day_h = t.day_h + 2'd1;
            end else begin
                n.day_l = t.day_l + 4'd1;
            end
        end
        if (c_year) begin
            n.month_h = 1'b0;
            n.month_l = 4'd1;
            if (t.year_l == 4'd9) begin
                n.year_l = 4'd0;
                n.year_h = (t.year_h == 4'd9) ? 4'd0 : t.year_h + 4'd1;
            end else begin
                n.year_l = t.year_l + 4'd1;
            end
        end else if (c_month) begin
            if (t.month_l == 4'd9) begin
                n.month_h = 1'b1;
                n.month_l = 4'd0;
            end else begin
                n.month_l = t.month_l + 4'd1;
            end
        end
        return n;
    endfunction

    state_t      state_q, state_d;
    cal_t        held_q, held_d;
    logic [42:0] a_q, a_d;
    logic [5:0]  b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  miss_q, miss_d;
    logic        sec00_q, sec00_d;
    logic        update_q, update_d;
    logic        frame_error_q, frame_error_d;

    logic        boundary, good, consistent, held_changed;
    cal_t        frame_dec, held_inc;
    logic [3:0]  cnt_inc;
    logic [7:0]  miss_inc;

    assign boundary   = bits_is_second_00_i && !sec00_q;
    assign frame_dec  = decode(a_q);
    assign good       = frame_ok(a_q, b_q, frame_dec);
    assign held_inc   = increment(held_q);
    assign consistent = (frame_dec == held_inc);
    assign cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    assign miss_inc   = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;

    // Shift in seconds, then evaluate the pre-shift frame at each boundary.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        held_d        = held_q;
        cnt_d         = cnt_q;
        miss_d        = miss_q;
        a_d           = a_q;
        b_d           = b_q;
        sec00_d       = bits_is_second_00_i;
        held_changed  = 1'b0;
        frame_error_d = 1'b0;
        if (bits_valid_i) begin
            a_d = {bits_data_i[0], a_q[42:1]};
            b_d = {bits_data_i[1], b_q[5:1]};
        end
        if (boundary) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (good) begin
                        held_d       = frame_dec;
                        held_changed = 1'b1;
                        cnt_d        = 4'd1;
                        state_d      = (CONFIRM_N <= 4'd1) ? ST_LOCKED : ST_CONFIRMING;
                    end
                end
                ST_CONFIRMING: begin
                    if (!good) begin
                        state_d       = ST_UNLOCKED;
                        cnt_d         = 4'd0;
                        frame_error_d = 1'b1;
                    end else begin
                        held_d       = frame_dec;
                        held_changed = 1'b1;
                        if (consistent) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= CONFIRM_N) state_d = ST_LOCKED;
                        end else begin
                            cnt_d         = 4'd1;
                            frame_error_d = 1'b1;
                        end
                    end
                end
                ST_LOCKED, ST_HOLDOVER: begin
                    held_changed = 1'b1;
                    if (!good) begin
                        held_d        = held_inc;
                        frame_error_d = 1'b1;
                        miss_d        = (state_q == ST_LOCKED) ? 8'd1 : miss_inc;
                        state_d       = (miss_d >= HOLDOVER_N) ? ST_UNLOCKED : ST_HOLDOVER;
                    end else begin
                        held_d = frame_dec;
                        miss_d = 8'd0;
                        if (consistent) begin
                            state_d = ST_LOCKED;
                        end else begin
                            state_d       = ST_CONFIRMING;
                            cnt_d         = 4'd1;
                            frame_error_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
        update_d = held_changed && ((state_d == ST_LOCKED) || (state_d == ST_HOLDOVER));
    end

    // State, held time, shifters and pulse registers; reset overrides all.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_UNLOCKED;
            held_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            miss_q        <= '0;
            sec00_q       <= 1'b0;
            update_q      <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_q        <= held_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            miss_q        <= miss_d;
            sec00_q       <= sec00_d;
            update_q      <= update_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign year_h_o      = held_q.year_h;
    assign year_l_o      = held_q.year_l;
    assign month_h_o     = held_q.month_h;
    assign month_l_o     = held_q.month_l;
    assign day_h_o       = held_q.day_h;
    assign day_l_o       = held_q.day_l;
    assign dow_o         = held_q.dow;
    assign hour_h_o      = held_q.hour_h;
    assign hour_l_o      = held_q.hour_l;
    assign minute_h_o    = held_q.minute_h;
    assign minute_l_o    = held_q.minute_l;
    assign valid_o       = (state_q == ST_LOCKED) || (state_q == ST_HOLDOVER);
    assign holdover_o    = (state_q == ST_HOLDOVER);
    assign update_o      = update_q;
    assign frame_error_o = frame_error_q;

endmodule
